jedro_1_dmem_arbiter: RTL and testbench



---
 rtl/jedro_1_dmem_pkg.sv | 15 +
 rtl/jedro_1_rr_arbiter.sv | 31 +++
 rtl/jedro_1_dmem_arbiter.sv | 83 ++++++++
 tb/tb_jedro_1_dmem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_dmem_pkg.sv
// Shared types for the jedro_1 data-memory arbiter: port count, port index and
// the one-cycle response record.
package jedro_1_dmem_pkg;

   localparam int NUM_PORTS = 2;

   typedef logic [$clog2(NUM_PORTS)-1:0] port_t;

   typedef struct packed {
      port_t port;
      logic  vld;
      logic  err;
   } resp_t;

endpackage

// File: rtl/jedro_1_rr_arbiter.sv
// Two-input grant logic. With JEDRO_1_DMEM_ARB_RR_EN defined, contention goes to
// the port not granted most recently; otherwise port 0 always wins.
module jedro_1_rr_arbiter
   import jedro_1_dmem_pkg::*;
(
`ifdef JEDRO_1_DMEM_ARB_RR_EN
   input  logic                 clk,
   input  logic                 rst,
`endif
   input  logic [NUM_PORTS-1:0] req,
   output logic [NUM_PORTS-1:0] gnt
);

`ifdef JEDRO_1_DMEM_ARB_RR_EN
   // prio names the port that wins the next contention
   port_t prio;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       prio <= '0;
      else if (|gnt) prio <= ~gnt[1];
   end

   always_comb begin
      gnt = req;
      if (&req) gnt = prio ? 2'b10 : 2'b01;
   end
`else
   assign gnt = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/jedro_1_dmem_arbiter.sv
// Shares the single-port data RAM between the core (port 0) and a secondary
// master (port 1). Arbitration mode selected by JEDRO_1_DMEM_ARB_RR_EN.
module jedro_1_dmem_arbiter
   import jedro_1_dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int RAM_AW     = 10
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [1:0]                req_i,
   input  logic [1:0]                we_i,
   input  logic [2*DATA_WIDTH/8-1:0] be_i,
   input  logic [2*ADDR_WIDTH-1:0]   addr_i,
   input  logic [2*DATA_WIDTH-1:0]   wdata_i,
   output logic [1:0]                gnt_o,
   output logic [1:0]                rvalid_o,
   output logic [1:0]                err_o,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      ram_en_o,
   output logic [DATA_WIDTH/8-1:0]   ram_we_o,
   output logic [RAM_AW-1:0]         ram_addr_o,
   output logic [DATA_WIDTH-1:0]     ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

   localparam int BE_W = DATA_WIDTH/8;

   port_t                 sel;
   logic                  acc, oor, we_sel;
   logic [BE_W-1:0]       be_sel;
   logic [ADDR_WIDTH-1:0] addr_sel, word;
   logic [DATA_WIDTH-1:0] wdata_sel;
   resp_t                 resp;
   logic                  resp_rd;

   jedro_1_rr_arbiter u_arb (
`ifdef JEDRO_1_DMEM_ARB_RR_EN
      .clk (clk_i),
      .rst (rst_i),
`endif
      .req (req_i),
      .gnt (gnt_o)
   );

   // Idle cycles select port 0, so the RAM address/data follow the core.
   assign sel = gnt_o[1];

   always_comb begin
      addr_sel    = sel ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
      wdata_sel   = sel ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
      be_sel      = sel ? be_i[2*BE_W-1:BE_W] : be_i[BE_W-1:0];
      we_sel      = we_i[sel];
      word        = addr_sel >> 2;
      oor         = |(word >> RAM_AW);
      acc         = |gnt_o;
      ram_en_o    = acc & ~oor;
      ram_we_o    = (ram_en_o & we_sel) ? be_sel : '0;
      ram_addr_o  = word[RAM_AW-1:0];
      ram_wdata_o = wdata_sel;
   end

   // resp_rd marks an in-range read whose RAM data is returned next cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         resp    <= '0;
         resp_rd <= 1'b0;
      end else begin
         resp    <= '{port: sel, vld: acc, err: acc & oor};
         resp_rd <= ram_en_o & ~we_sel;
      end
   end

   always_comb begin
      rvalid_o            = '0;
      err_o               = '0;
      rvalid_o[resp.port] = resp.vld;
      err_o[resp.port]    = resp.err;
      rdata_o             = resp_rd ? ram_rdata_i : '0;
   end

endmodule

// File: tb/tb_jedro_1_dmem_arbiter.sv
// Directed bench for jedro_1_dmem_arbiter with a behavioural no-change RAM;
// expected contention grants follow JEDRO_1_DMEM_ARB_RR_EN.
module tb_jedro_1_dmem_arbiter;

   localparam int DW = 32, AW = 32, RAW = 10, BW = DW/8;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req, we;
   logic [2*BW-1:0]  be;
   logic [2*AW-1:0]  addr;
   logic [2*DW-1:0]  wdata;
   logic [1:0]       gnt, rvalid, err;
   logic [DW-1:0]    rdata;
   logic             ram_en;
   logic [BW-1:0]    ram_we;
   logic [RAW-1:0]   ram_addr;
   logic [DW-1:0]    ram_wdata, ram_rdata;

   logic [DW-1:0]    mem [0:(1<<RAW)-1];

   int nchk = 0, nerr = 0;

   always #5 clk = ~clk;

   jedro_1_dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_AW(RAW)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
      .err_o(err), .rdata_o(rdata), .ram_en_o(ram_en), .ram_we_o(ram_we),
      .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
   );

   // single-port no-change RAM: read data only updates on non-write accesses
   always @(posedge clk) begin
      if (ram_en) begin
         for (int b = 0; b < BW; b++)
            if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
         if (ram_we == '0) ram_rdata <= mem[ram_addr];
      end
   end

   typedef struct {
      logic [1:0]     req, we;
      logic [BW-1:0]  be0;
      logic [AW-1:0]  a0, a1;
      logic [DW-1:0]  d0;
      logic [1:0]     gnt;
      logic           en;
      logic [BW-1:0]  rwe;
      logic [RAW-1:0] raddr;
      logic [1:0]     rv, er;
      logic [DW-1:0]  rd;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   function automatic vec_t mk(input int rq, input int w, input int b0,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d0, input int g, input int en,
                               input int rwe, input int ra, input int rv,
                               input int er, input logic [31:0] rd);
      vec_t v;
      v.req = 2'(rq); v.we = 2'(w); v.be0 = BW'(b0);
      v.a0 = a0; v.a1 = a1; v.d0 = d0;
      v.gnt = 2'(g); v.en = 1'(en); v.rwe = BW'(rwe); v.raddr = RAW'(ra);
      v.rv = 2'(rv); v.er = 2'(er); v.rd = rd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      req   = v.req;
      we    = v.we;
      be    = {BW'(0), v.be0};
      addr  = {v.a1, v.a0};
      wdata = {DW'(0), v.d0};
   endtask

   logic [1:0] exp_g, prev_g;
   int         p1_grants;

   initial begin
      for (int i = 0; i < (1<<RAW); i++) mem[i] = '0;
      ram_rdata = '0;
      rst = 1'b1; req = '0; we = '0; be = '0; addr = '0; wdata = '0;

      //      req we  be  a0           a1        d0           gnt en we raddr rv er rd
      vecs[0]  = mk(0, 0, 0,  0,           0,        0,           0, 0, 0, 0,  0, 0, 0);
      vecs[1]  = mk(1, 1, 15, 0,           0,        13,          1, 1, 15, 0, 0, 0, 0);
      vecs[2]  = mk(1, 1, 15, 4,           0,        13,          1, 1, 15, 1, 1, 0, 0);
      vecs[3]  = mk(2, 0, 0,  0,           4,        0,           2, 1, 0, 1,  1, 0, 0);
      vecs[4]  = mk(0, 0, 0,  0,           0,        0,           0, 0, 0, 0,  2, 0, 13);
      vecs[5]  = mk(1, 1, 2,  8,           0,        32'hAABBCCDD, 1, 1, 2, 2, 0, 0, 0);
      vecs[6]  = mk(1, 0, 0,  8,           0,        0,           1, 1, 0, 2,  1, 0, 0);
      vecs[7]  = mk(0, 0, 0,  0,           0,        0,           0, 0, 0, 0,  1, 0, 32'h0000CC00);
      vecs[8]  = mk(2, 0, 0,  0,           1<<(RAW+2), 0,         2, 0, 0, 0,  0, 0, 0);
      vecs[9]  = mk(1, 1, 15, 32'h80000004, 0,       32'hFFFFFFFF, 1, 0, 0, 1, 2, 2, 0);
      vecs[10] = mk(2, 0, 0,  0,           4,        0,           2, 1, 0, 1,  1, 1, 0);
      vecs[11] = mk(0, 0, 0,  0,           0,        0,           0, 0, 0, 0,  2, 0, 13);

      // reset state
      repeat (2) @(negedge clk);
      chk("rst gnt",    32'(gnt),    0);
      chk("rst rvalid", 32'(rvalid), 0);
      chk("rst err",    32'(err),    0);
      chk("rst rdata",  rdata,       0);
      chk("rst ram_en", 32'(ram_en), 0);
      chk("rst ram_we", 32'(ram_we), 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d gnt", i),      32'(gnt),      32'(vecs[i].gnt));
         chk($sformatf("v%0d ram_en", i),   32'(ram_en),   32'(vecs[i].en));
         chk($sformatf("v%0d ram_we", i),   32'(ram_we),   32'(vecs[i].rwe));
         chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].raddr));
         chk($sformatf("v%0d rvalid", i),   32'(rvalid),   32'(vecs[i].rv));
         chk($sformatf("v%0d err", i),      32'(err),      32'(vecs[i].er));
         chk($sformatf("v%0d rdata", i),    rdata,         vecs[i].rd);
      end
      chk("ram[0]", mem[0], 13);
      chk("ram[1]", mem[1], 13);
      chk("ram[2]", mem[2], 32'h0000CC00);

      // both ports request every cycle: port 0 reads word 0, port 1 reads word 2
      prev_g = 2'b00;
      p1_grants = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         req = 2'b11; we = 2'b00; be = '0; addr = {32'h8, 32'h0}; wdata = '0;
         #1;
`ifdef JEDRO_1_DMEM_ARB_RR_EN
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp_g = 2'b01;
`endif
         chk($sformatf("cont%0d gnt", i), 32'(gnt), 32'(exp_g));
         if (i > 0) begin
            chk($sformatf("cont%0d rvalid", i), 32'(rvalid), 32'(prev_g));
            chk($sformatf("cont%0d rdata", i), rdata, prev_g[1] ? 32'h0000CC00 : 32'd13);
         end
         p1_grants += 32'(gnt[1]);
         prev_g = exp_g;
      end
      @(negedge clk);
      req = 2'b00; addr = '0;
      #1;
      chk("cont tail rvalid", 32'(rvalid), 32'(prev_g));
      chk("cont tail rdata", rdata, prev_g[1] ? 32'h0000CC00 : 32'd13);
`ifdef JEDRO_1_DMEM_ARB_RR_EN
      chk("cont p1 grants", 32'(p1_grants), 4);
`else
      chk("cont p1 grants", 32'(p1_grants), 0);
`endif

      // reset pulsed the cycle after a granted read drops the response
      @(negedge clk);
      req = 2'b01; we = 2'b00; addr = {32'h0, 32'h4};
      #1;
      chk("rp gnt", 32'(gnt), 1);
      @(negedge clk);
      rst = 1'b1; req = 2'b00; addr = '0;
      #1;
      chk("rp rvalid", 32'(rvalid), 0);
      chk("rp err",    32'(err),    0);
      chk("rp rdata",  rdata,       0);
      chk("rp gnt0",   32'(gnt),    0);
      chk("rp ram_en", 32'(ram_en), 0);
      chk("rp ram_we", 32'(ram_we), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rp post rvalid", 32'(rvalid), 0);
      @(negedge clk);
      req = 2'b11; addr = {32'h8, 32'h0};
      #1;
      chk("rp prio gnt", 32'(gnt), 1);
      @(negedge clk);
      req = 2'b00; addr = '0;
      #1;
      chk("rp resp rvalid", 32'(rvalid), 1);
      chk("rp resp rdata",  rdata,       13);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
